// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load format codes and
// default datapath widths used by the MEM/WB slice.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef logic [2:0] ld_type_t;

  localparam ld_type_t LD_W  = 3'b000;
  localparam ld_type_t LD_H  = 3'b001;
  localparam ld_type_t LD_HU = 3'b010;
  localparam ld_type_t LD_B  = 3'b011;
  localparam ld_type_t LD_BU = 3'b100;

endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// MEM-stage inputs and WB-stage outputs of the MEM/WB register.
// slave is the register itself, master is the surrounding pipeline.
interface mem_wb_pipe_reg_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
);

  logic              me_valid;
  logic [DATA_W-1:0] me_alu_res;
  logic [DATA_W-1:0] me_mem_rdata;
  logic [2:0]        me_ld_type;
  logic              me_mem2reg;
  logic [REG_AW-1:0] me_td;
  logic              me_wreg;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [REG_AW-1:0] wb_td;
  logic              wb_wreg;
  logic              wb_misalign;

  modport slave (
    input  me_valid,
    input  me_alu_res,
    input  me_mem_rdata,
    input  me_ld_type,
    input  me_mem2reg,
    input  me_td,
    input  me_wreg,
    output wb_valid,
    output wb_data,
    output wb_td,
    output wb_wreg,
    output wb_misalign
  );

  modport master (
    output me_valid,
    output me_alu_res,
    output me_mem_rdata,
    output me_ld_type,
    output me_mem2reg,
    output me_td,
    output me_wreg,
    input  wb_valid,
    input  wb_data,
    input  wb_td,
    input  wb_wreg,
    input  wb_misalign
  );

endinterface

// File: rtl/load_align.sv
// Big-endian load lane select with sign/zero extension and
// alignment check for LW/LH/LHU/LB/LBU.
module load_align
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        a,
  input  ld_type_t          ld_type,
  output logic [DATA_W-1:0] ld_fmt,
  output logic              mis
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // lane 0 is the most significant byte
  always_comb begin
    byte_sel = rdata[7:0];
    unique case (a)
      2'd0: byte_sel = rdata[31:24];
      2'd1: byte_sel = rdata[23:16];
      2'd2: byte_sel = rdata[15:8];
      2'd3: byte_sel = rdata[7:0];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = a[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    ld_fmt = rdata;
    mis    = (a != 2'd0);
    unique case (ld_type)
      LD_H: begin
        ld_fmt = {{(DATA_W-16){half_sel[15]}}, half_sel};
        mis    = a[0];
      end
      LD_HU: begin
        ld_fmt = {{(DATA_W-16){1'b0}}, half_sel};
        mis    = a[0];
      end
      LD_B: begin
        ld_fmt = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
        mis    = 1'b0;
      end
      LD_BU: begin
        ld_fmt = {{(DATA_W-8){1'b0}}, byte_sel};
        mis    = 1'b0;
      end
      default: begin
        ld_fmt = rdata;
        mis    = (a != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: valid tracking, stall/flush,
// load formatting, misaligned-load flag and retire counter.
module mem_wb_pipe_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_wb_pipe_reg_if.slave bus,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [DATA_W-1:0] ld_fmt;
  logic              mis;
  logic              ld_mis;

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [REG_AW-1:0] td_d, td_q;
  logic              wreg_d, wreg_q;
  logic              misal_d, misal_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .rdata   (bus.me_mem_rdata),
    .a       (bus.me_alu_res[1:0]),
    .ld_type (bus.me_ld_type),
    .ld_fmt  (ld_fmt),
    .mis     (mis)
  );

  assign ld_mis = bus.me_mem2reg & mis;

  // flush beats stall; a flush never touches the counter
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    td_d    = td_q;
    wreg_d  = wreg_q;
    misal_d = misal_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      td_d    = '0;
      wreg_d  = 1'b0;
      misal_d = 1'b0;
    end else if (!stall) begin
      valid_d = bus.me_valid;
      td_d    = bus.me_td;
      data_d  = bus.me_mem2reg ? ld_fmt
                               : bus.me_alu_res;
      misal_d = bus.me_valid & ld_mis;
      wreg_d  = bus.me_valid & bus.me_wreg
              & (bus.me_td != '0) & ~ld_mis;
      if (bus.me_valid)
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      td_q    <= '0;
      wreg_q  <= 1'b0;
      misal_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      td_q    <= td_d;
      wreg_q  <= wreg_d;
      misal_q <= misal_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wb_valid    = valid_q;
  assign bus.wb_data     = data_q;
  assign bus.wb_td       = td_q;
  assign bus.wb_wreg     = wreg_q;
  assign bus.wb_misalign = misal_q;
  assign retire_cnt      = cnt_q;

endmodule
